// File: rtl/scr1_dmi_chain_ctrl_pkg.sv
// Shared constants and types for the SysCLK-side DMI chain controller:
// chain IDs, DMI op/status encodings, DTMCS field positions and FSM states.
package scr1_dmi_chain_ctrl_pkg;

    localparam int unsigned SCR1_DBG_DMI_CH_ID_WIDTH_DEF = 2;
    localparam int unsigned SCR1_DBG_DMI_ADDR_WIDTH_DEF  = 7;
    localparam int unsigned SCR1_DBG_DMI_DATA_WIDTH_DEF  = 32;
    localparam int unsigned SCR1_DBG_DMI_OP_WIDTH_DEF    = 2;

    localparam int unsigned CH_ID_DTMCS      = 1;
    localparam int unsigned CH_ID_DMI_ACCESS = 2;

    localparam int unsigned DTMCS_WIDTH      = 32;
    localparam int unsigned DMI_ACCESS_WIDTH = 41;

    localparam logic [1:0] DMI_OP_NOP     = 2'd0;
    localparam logic [1:0] DMI_OP_READ    = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE   = 2'd2;
    localparam logic [1:0] DMI_ST_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_ST_BUSY    = 2'd3;

    localparam int unsigned DTMCS_VERSION_LSB   = 0;
    localparam int unsigned DTMCS_ABITS_LSB     = 4;
    localparam int unsigned DTMCS_DMISTAT_LSB   = 10;
    localparam int unsigned DTMCS_IDLE_LSB      = 12;
    localparam int unsigned DTMCS_DMIRESET_BIT  = 16;
    localparam int unsigned DTMCS_HARDRESET_BIT = 17;

    typedef enum logic {
        StIdle,
        StReq
    } dmi_state_e;

    // Read-only DTMCS image; dmistat mirrors the sticky busy flag.
    function automatic logic [DTMCS_WIDTH-1:0] dtmcs_value(input logic busy,
                                                           input logic [5:0] abits);
        logic [DTMCS_WIDTH-1:0] v;
        v = '0;
        v[DTMCS_VERSION_LSB +: 4] = 4'd1;
        v[DTMCS_ABITS_LSB +: 6]   = abits;
        v[DTMCS_DMISTAT_LSB +: 2] = {2{busy}};
        v[DTMCS_IDLE_LSB +: 3]    = 3'd1;
        return v;
    endfunction

endpackage

// File: rtl/scr1_dmi_shreg.sv
// Generic capture/shift register; shifts toward bit 0, which drives TDO.
module scr1_dmi_shreg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             shift,
    input  logic             tdi,
    input  logic [Width-1:0] cap_data,
    output logic [Width-1:0] data,
    output logic             tdo
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (capture) begin
            data_q <= cap_data;
        end else if (shift) begin
            data_q <= {tdi, data_q[Width-1:1]};
        end
    end

    assign data = data_q;
    assign tdo  = data_q[0];

endmodule

// File: rtl/scr1_dmi_chain_ctrl.sv
// SysCLK-domain DTMCS / DMI_ACCESS chain handler with DM req/resp handshake.
// Optional: define SCR1_DBG_DMI_HARDRESET_EN to honour DTMCS.dmihardreset.
module scr1_dmi_chain_ctrl
    import scr1_dmi_chain_ctrl_pkg::*;
#(
    parameter int unsigned SCR1_DBG_DMI_CH_ID_WIDTH = SCR1_DBG_DMI_CH_ID_WIDTH_DEF,
    parameter int unsigned SCR1_DBG_DMI_ADDR_WIDTH  = SCR1_DBG_DMI_ADDR_WIDTH_DEF,
    parameter int unsigned SCR1_DBG_DMI_DATA_WIDTH  = SCR1_DBG_DMI_DATA_WIDTH_DEF,
    parameter int unsigned SCR1_DBG_DMI_OP_WIDTH    = SCR1_DBG_DMI_OP_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tapcsync2dmi_ch_sel_i,
    input  logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] tapcsync2core_ch_id_i,
    input  logic                                tapcsync2core_ch_capture_i,
    input  logic                                tapcsync2core_ch_shift_i,
    input  logic                                tapcsync2core_ch_update_i,
    input  logic                                tapcsync2core_ch_tdi_i,
    output logic                                tapcsync2core_ch_tdo_o,
    output logic                                dmi2dm_req_o,
    output logic                                dmi2dm_wr_o,
    output logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0]  dmi2dm_addr_o,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]  dmi2dm_wdata_o,
    input  logic                                dm2dmi_resp_i,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]  dm2dmi_rdata_i
);

    localparam int unsigned AW   = SCR1_DBG_DMI_ADDR_WIDTH;
    localparam int unsigned DW   = SCR1_DBG_DMI_DATA_WIDTH;
    localparam int unsigned OW   = SCR1_DBG_DMI_OP_WIDTH;
    localparam int unsigned DmiW = AW + DW + OW;
    localparam int unsigned IdW  = SCR1_DBG_DMI_CH_ID_WIDTH;

    dmi_state_e       state;
    logic             req_q;
    logic             wr_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    data_q;
    logic             busy_q;

    logic             is_dtmcs;
    logic             is_dmi;
    logic             capture;
    logic             update;
    logic             shift;
    logic [DTMCS_WIDTH-1:0] dtmcs_sh;
    logic [DmiW-1:0]  dmi_sh;
    logic             dtmcs_tdo;
    logic             dmi_tdo;
    logic             dmi_op_busy;
    logic [OW-1:0]    dmi_cap_op;
    logic [OW-1:0]    upd_op;
    logic             unused_dtmcs_bits;

    assign is_dtmcs = tapcsync2dmi_ch_sel_i && (tapcsync2core_ch_id_i == IdW'(CH_ID_DTMCS));
    assign is_dmi   = tapcsync2dmi_ch_sel_i && (tapcsync2core_ch_id_i == IdW'(CH_ID_DMI_ACCESS));

    // Strobe priority: capture > update > shift.
    assign capture = tapcsync2core_ch_capture_i;
    assign update  = tapcsync2core_ch_update_i & ~capture;
    assign shift   = tapcsync2core_ch_shift_i & ~capture & ~tapcsync2core_ch_update_i;

    assign dmi_op_busy = (state != StIdle) || busy_q;
    assign dmi_cap_op  = dmi_op_busy ? OW'(DMI_ST_BUSY) : OW'(DMI_ST_SUCCESS);
    assign upd_op      = dmi_sh[OW-1:0];

    scr1_dmi_shreg #(
        .Width (DTMCS_WIDTH)
    ) u_dtmcs_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (is_dtmcs & capture),
        .shift    (is_dtmcs & shift),
        .tdi      (tapcsync2core_ch_tdi_i),
        .cap_data (dtmcs_value(busy_q, 6'(AW))),
        .data     (dtmcs_sh),
        .tdo      (dtmcs_tdo)
    );

    scr1_dmi_shreg #(
        .Width (DmiW)
    ) u_dmi_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (is_dmi & capture),
        .shift    (is_dmi & shift),
        .tdi      (tapcsync2core_ch_tdi_i),
        .cap_data ({addr_q, data_q, dmi_cap_op}),
        .data     (dmi_sh),
        .tdo      (dmi_tdo)
    );

    assign unused_dtmcs_bits = ^{dtmcs_sh[31:17], dtmcs_sh[15:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            req_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (is_dmi && capture && dmi_op_busy) begin
                busy_q <= 1'b1;
            end
            if (is_dtmcs && update && dtmcs_sh[DTMCS_DMIRESET_BIT]) begin
                busy_q <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (is_dmi && update && !busy_q &&
                        (upd_op == OW'(DMI_OP_READ) || upd_op == OW'(DMI_OP_WRITE))) begin
                        state  <= StReq;
                        req_q  <= 1'b1;
                        wr_q   <= (upd_op == OW'(DMI_OP_WRITE));
                        addr_q <= dmi_sh[DmiW-1 -: AW];
                        data_q <= dmi_sh[OW +: DW];
                    end
                end
                StReq: begin
                    if (dm2dmi_resp_i) begin
                        state <= StIdle;
                        req_q <= 1'b0;
                        if (!wr_q) begin
                            data_q <= dm2dmi_rdata_i;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
`ifdef SCR1_DBG_DMI_HARDRESET_EN
            // Abandon any outstanding request; a late resp then lands in IDLE.
            if (is_dtmcs && update && dtmcs_sh[DTMCS_HARDRESET_BIT]) begin
                state  <= StIdle;
                req_q  <= 1'b0;
                busy_q <= 1'b0;
            end
`endif
        end
    end

    assign tapcsync2core_ch_tdo_o = is_dtmcs ? dtmcs_tdo : (is_dmi ? dmi_tdo : 1'b0);
    assign dmi2dm_req_o   = req_q;
    assign dmi2dm_wr_o    = wr_q;
    assign dmi2dm_addr_o  = addr_q;
    assign dmi2dm_wdata_o = data_q;

endmodule
